// File: rtl/red_pitaya_exp_pkg.sv
// Shared constants for the expansion-connector input conditioning block:
// register offsets and default bank / debounce widths.
package red_pitaya_exp_pkg;

  localparam int EXP_DWE = 8;
  localparam int EXP_DBW = 16;

  localparam logic [19:0] EXP_DEB_LEN_ADDR  = 20'h00;
  localparam logic [19:0] EXP_RISE_EN_ADDR  = 20'h04;
  localparam logic [19:0] EXP_FALL_EN_ADDR  = 20'h08;
  localparam logic [19:0] EXP_STATUS_ADDR   = 20'h0C;
  localparam logic [19:0] EXP_IRQ_MASK_ADDR = 20'h10;
  localparam logic [19:0] EXP_LEVEL_ADDR    = 20'h14;

endpackage

// File: rtl/red_pitaya_exp_sync_debounce.sv
// One-bit input conditioner: two-flop synchronizer followed by an optional
// debouncer (EXP_SYNC_DEBOUNCE_EN); without it the synchronized level passes through.
module exp_debounce
  import red_pitaya_exp_pkg::*;
#(
  parameter int DBW = EXP_DBW
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           raw_i,
  input  logic [DBW-1:0] len_i,
  output logic           deb_o
);

  logic sync_meta;
  logic sync;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw_i;
      sync      <= sync_meta;
    end
  end

`ifdef EXP_SYNC_DEBOUNCE_EN
  logic [DBW-1:0] cnt;
  logic [DBW-1:0] term;
  logic           deb;

  // A length of 0 behaves like 1: accept after a single mismatching cycle.
  assign term = (len_i == '0) ? '0 : len_i - 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync != deb) begin
      if (cnt == term) begin
        deb <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign deb_o = deb;
`else
  logic unused_len;
  assign unused_len = ^len_i;
  assign deb_o      = sync;
`endif

endmodule

// File: rtl/red_pitaya_exp_sync.sv
// Expansion-connector input conditioning: per-bit sync/debounce, sticky edge
// status with maskable irq, own bus register window. Debounce via EXP_SYNC_DEBOUNCE_EN.
module red_pitaya_exp_sync
  import red_pitaya_exp_pkg::*;
#(
  parameter int DWE = EXP_DWE,
  parameter int DBW = EXP_DBW
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [DWE-1:0] exp_p_raw_i,
  input  logic [DWE-1:0] exp_n_raw_i,
  output logic [DWE-1:0] exp_p_dat_o,
  output logic [DWE-1:0] exp_n_dat_o,
  output logic           irq_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);

  localparam int VW = 2 * DWE;

  logic [VW-1:0]  raw_vec;
  logic [VW-1:0]  deb_vec;
  logic [VW-1:0]  deb_prev;
  logic [VW-1:0]  rise_en;
  logic [VW-1:0]  fall_en;
  logic [VW-1:0]  status;
  logic [VW-1:0]  irq_mask;
  logic [VW-1:0]  edge_set;
  logic [VW-1:0]  w1c;
  logic [DBW-1:0] deb_len;
  logic [19:0]    addr;
  logic [31:0]    rd_mux;
  logic           unused_bus;

  assign addr       = sys_addr[19:0];
  assign raw_vec    = {exp_n_raw_i, exp_p_raw_i};
  assign unused_bus = &{1'b0, sys_addr, sys_wdata};

  for (genvar i = 0; i < VW; i++) begin : g_bit
    exp_debounce #(.DBW(DBW)) u_deb (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .raw_i (raw_vec[i]),
      .len_i (deb_len),
      .deb_o (deb_vec[i])
    );
  end

  assign exp_p_dat_o = deb_vec[DWE-1:0];
  assign exp_n_dat_o = deb_vec[VW-1:DWE];
  assign sys_err     = 1'b0;

`ifdef EXP_SYNC_DEBOUNCE_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      deb_len <= '0;
    else if (sys_wen && addr == EXP_DEB_LEN_ADDR)
      deb_len <= sys_wdata[DBW-1:0];
  end
`else
  assign deb_len = '0;
`endif

  assign edge_set = (deb_vec & ~deb_prev & rise_en) | (~deb_vec & deb_prev & fall_en);
  assign w1c      = (sys_wen && addr == EXP_STATUS_ADDR) ? sys_wdata[VW-1:0] : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
      status   <= '0;
      deb_prev <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (sys_wen && addr == EXP_RISE_EN_ADDR)  rise_en  <= sys_wdata[VW-1:0];
      if (sys_wen && addr == EXP_FALL_EN_ADDR)  fall_en  <= sys_wdata[VW-1:0];
      if (sys_wen && addr == EXP_IRQ_MASK_ADDR) irq_mask <= sys_wdata[VW-1:0];
      // A fresh edge in the same cycle as its clear keeps the bit set.
      status   <= (status & ~w1c) | edge_set;
      deb_prev <= deb_vec;
      irq_o    <= |(status & irq_mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      EXP_DEB_LEN_ADDR:  rd_mux = 32'(deb_len);
      EXP_RISE_EN_ADDR:  rd_mux = 32'(rise_en);
      EXP_FALL_EN_ADDR:  rd_mux = 32'(fall_en);
      EXP_STATUS_ADDR:   rd_mux = 32'(status);
      EXP_IRQ_MASK_ADDR: rd_mux = 32'(irq_mask);
      EXP_LEVEL_ADDR:    rd_mux = 32'(deb_vec);
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_exp_sync.sv
// Self-checking bench for red_pitaya_exp_sync: window-based behavioural model
// compared every cycle, plus directed literal checks. Follows EXP_SYNC_DEBOUNCE_EN.
module tb_red_pitaya_exp_sync;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  exp_p_raw_i = 8'h00;
  logic [7:0]  exp_n_raw_i = 8'h00;
  logic [7:0]  exp_p_dat_o;
  logic [7:0]  exp_n_dat_o;
  logic        irq_o;
  logic [31:0] sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic        sys_wen = 1'b0;
  logic        sys_ren = 1'b0;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  int tests = 0;
  int failed = 0;
  bit chk_on = 1'b0;

`ifdef EXP_SYNC_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  red_pitaya_exp_sync dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .exp_p_raw_i(exp_p_raw_i), .exp_n_raw_i(exp_n_raw_i),
    .exp_p_dat_o(exp_p_dat_o), .exp_n_dat_o(exp_n_dat_o),
    .irq_o(irq_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level is accepted once the synchronized pin has shown
  // the opposite value for the last L samples in a row.
  logic [15:0] m_s1, m_s2, m_deb, m_deb_prev;
  logic [15:0] m_rise, m_fall, m_status, m_mask, m_deb_len;
  logic [15:0] m_set, m_w1c, m_nd;
  logic        m_irq, m_ack, m_rd, m_all;
  logic [31:0] m_rdata;
  logic [15:0] shist[$];
  int          m_len;

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_prev = '0;
      m_rise = '0; m_fall = '0; m_status = '0; m_mask = '0; m_deb_len = '0;
      m_irq = 0; m_ack = 0; m_rd = 0; m_rdata = '0;
      shist.delete();
    end else begin
      m_ack   = sys_wen | sys_ren;
      m_rd    = sys_ren;
      m_rdata = '0;
      if (sys_ren)
        case (sys_addr[19:0])
          20'h00: m_rdata = {16'h0, m_deb_len};
          20'h04: m_rdata = {16'h0, m_rise};
          20'h08: m_rdata = {16'h0, m_fall};
          20'h0C: m_rdata = {16'h0, m_status};
          20'h10: m_rdata = {16'h0, m_mask};
          20'h14: m_rdata = {16'h0, m_deb};
          default: m_rdata = '0;
        endcase
      m_set = (m_deb & ~m_deb_prev & m_rise) | (~m_deb & m_deb_prev & m_fall);
      m_w1c = (sys_wen && sys_addr[19:0] == 20'h0C) ? sys_wdata[15:0] : '0;
      m_irq = |(m_status & m_mask);
      m_status = (m_status & ~m_w1c) | m_set;
      m_deb_prev = m_deb;
      if (DEB_ON) begin
        m_len = (m_deb_len == 0) ? 1 : int'(m_deb_len);
        shist.push_front(m_s2);
        if (shist.size() > 64) void'(shist.pop_back());
        m_nd = m_deb;
        for (int b = 0; b < 16; b++) begin
          if (shist.size() >= m_len) begin
            m_all = 1'b1;
            for (int j = 0; j < m_len; j++)
              if (shist[j][b] == m_deb[b]) m_all = 1'b0;
            if (m_all) m_nd[b] = ~m_deb[b];
          end
        end
        m_deb = m_nd;
        m_s2 = m_s1;
        m_s1 = {exp_n_raw_i, exp_p_raw_i};
      end else begin
        m_s2 = m_s1;
        m_s1 = {exp_n_raw_i, exp_p_raw_i};
        m_deb = m_s2;
      end
      if (sys_wen) begin
        case (sys_addr[19:0])
          20'h00: if (DEB_ON) m_deb_len = sys_wdata[15:0];
          20'h04: m_rise = sys_wdata[15:0];
          20'h08: m_fall = sys_wdata[15:0];
          20'h10: m_mask = sys_wdata[15:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("exp_p_dat", {24'h0, exp_p_dat_o}, {24'h0, m_deb[7:0]});
      chk("exp_n_dat", {24'h0, exp_n_dat_o}, {24'h0, m_deb[15:8]});
      chk("irq", {31'h0, irq_o}, {31'h0, m_irq});
      chk("ack", {31'h0, sys_ack}, {31'h0, m_ack});
      chk("err", {31'h0, sys_err}, 32'h0);
      if (m_rd) chk("rdata", sys_rdata, m_rdata);
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(negedge clk_i);
    sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_i);
    sys_addr = a; sys_ren = 1'b1;
    @(negedge clk_i);
    sys_ren = 1'b0;
    d = sys_rdata;
  endtask

  logic [31:0] rd;
  int          set_edge;
  int          lat;

  initial begin
    exp_p_raw_i = 8'hFF;
    repeat (3) @(negedge clk_i);
    chk("rst_p_dat", {24'h0, exp_p_dat_o}, 32'h0);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_ack", {31'h0, sys_ack}, 32'h0);
    chk("rst_rdata", sys_rdata, 32'h0);
    rstn_i = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rel_p_dat", {24'h0, exp_p_dat_o}, 32'h0000_00FF);
    bus_read(32'h0C, rd); chk("rel_status", rd, 32'h0);
    chk("rel_irq", {31'h0, irq_o}, 32'h0);
    bus_read(32'h00, rd); chk("deb_len_rst", rd, 32'h0);

    exp_p_raw_i = 8'h00;
    repeat (10) @(negedge clk_i);
    bus_write(32'h00, 32'd5);
    bus_read(32'h00, rd); chk("deb_len_rd", rd, DEB_ON ? 32'd5 : 32'd0);

    // 4-cycle glitch on p[0]
    @(negedge clk_i); exp_p_raw_i = 8'h01;
    repeat (4) begin
      @(negedge clk_i);
      if (DEB_ON) chk("glitch_lvl", {31'h0, exp_p_dat_o[0]}, 32'h0);
    end
    exp_p_raw_i = 8'h00;
    repeat (10) @(negedge clk_i);
    bus_read(32'h14, rd); chk("glitch_level_reg", rd, 32'h0);

    // held pin: level appears after edge k+1+max(DEB_LEN,1)
    lat = DEB_ON ? 6 : 1;
    @(negedge clk_i); exp_p_raw_i = 8'h01;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk_i);
      chk("held_lvl", {31'h0, exp_p_dat_o[0]}, (j >= lat + 1) ? 32'h1 : 32'h0);
    end
    bus_read(32'h14, rd); chk("held_level_reg", rd, 32'h0000_0001);

    // edge capture on n[0]
    bus_write(32'h00, 32'd2);
    bus_write(32'h04, 32'h0100);
    bus_write(32'h10, 32'h0100);
    bus_write(32'h08, 32'h0);
    @(negedge clk_i); exp_n_raw_i = 8'h01;
    repeat (20) @(negedge clk_i);
    exp_n_raw_i = 8'h00;
    repeat (10) @(negedge clk_i);
    bus_read(32'h0C, rd); chk("status_rise", rd, 32'h0000_0100);
    chk("irq_set", {31'h0, irq_o}, 32'h1);

    // W1C clears irq two edges after the strobe
    bus_write(32'h0C, 32'h0100);
    chk("irq_w1c_1", {31'h0, irq_o}, 32'h1);
    @(negedge clk_i);
    chk("irq_w1c_2", {31'h0, irq_o}, 32'h0);
    bus_read(32'h0C, rd); chk("status_clr", rd, 32'h0);

    // W1C on the same edge that sets the bit: set wins
    set_edge = DEB_ON ? 4 : 2;
    @(negedge clk_i); exp_n_raw_i = 8'h01;
    repeat (set_edge - 1) @(negedge clk_i);
    bus_write(32'h0C, 32'h0100);
    repeat (3) @(negedge clk_i);
    bus_read(32'h0C, rd); chk("status_set_wins", rd, 32'h0000_0100);
    chk("irq_set_wins", {31'h0, irq_o}, 32'h1);

    // falling capture on p[1]
    bus_write(32'h08, 32'h0002);
    @(negedge clk_i); exp_p_raw_i = 8'h03;
    repeat (10) @(negedge clk_i);
    exp_p_raw_i = 8'h01;
    repeat (10) @(negedge clk_i);
    bus_read(32'h0C, rd); chk("status_fall", rd, 32'h0000_0102);

    // bus decode
    bus_read(32'h40, rd); chk("rd_unmapped", rd, 32'h0);
    chk("ack_unmapped", {31'h0, sys_ack}, 32'h1);
    bus_write(32'h40, 32'hDEAD_BEEF);
    bus_write(32'h10, 32'hFFFF_FFFF);
    bus_read(32'h10, rd); chk("mask_rd", rd, 32'h0000_FFFF);
    bus_read(32'h14, rd); chk("level_rd", rd, 32'h0101);
    repeat (4) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
